// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and the long-latency unit.
// Optional same-cycle result bypass when WB_BYPASS_EN is defined.
package wb_port_arbiter_pkg;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [63:0] word_t;

    typedef struct packed {
        creg_addr_t dst;
        word_t      data;
    } lu_entry_t;

endpackage

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  creg_addr_t  wb_wa,
    input  word_t       wb_wd,
    output logic        pipe_stall,
    input  logic        lu_issue,
    input  creg_addr_t  lu_issue_dst,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  creg_addr_t  lu_dst,
    input  word_t       lu_data,
    output logic        rf_we,
    output creg_addr_t  rf_wa,
    output word_t       rf_wd,
    output logic [31:0] busy_mask
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = $clog2(DEPTH + 1);
    localparam int StW  = $clog2(STARVE_LIMIT + 1);

    lu_entry_t        fifoMem [DEPTH];
    logic [PtrW-1:0]  rdPtr;
    logic [PtrW-1:0]  wrPtr;
    logic [CntW-1:0]  count;
    logic [StW-1:0]   starveCnt;
    logic             stallQ;
    logic [31:0]      busyQ;

    lu_entry_t        head;
    logic             full;
    logic             empty;
    logic             grantFifo;
    logic             grantPipe;
    logic             bypass;
    logic             push;
    logic             pop;
    creg_addr_t       wrAddr;
    word_t            wrData;
    logic [CntW-1:0]  countNext;
    logic [StW-1:0]   starveNext;
    logic [31:0]      busyNext;

    assign head  = fifoMem[rdPtr];
    assign full  = (count == CntW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        grantFifo = !reset && !empty && (stallQ || !wb_valid);
        grantPipe = !reset && wb_valid && !stallQ && !grantFifo;
`ifdef WB_BYPASS_EN
        bypass = !reset && empty && !wb_valid && !stallQ && lu_valid;
`else
        bypass = 1'b0;
`endif
        lu_ready = !reset && !full;
        push     = lu_valid && lu_ready && !bypass;
        pop      = grantFifo;
    end

    // Grants are mutually exclusive by construction.
    always_comb begin
        wrAddr = '0;
        wrData = '0;
        unique case (1'b1)
            grantFifo: begin
                wrAddr = head.dst;
                wrData = head.data;
            end
            grantPipe: begin
                wrAddr = wb_wa;
                wrData = wb_wd;
            end
            bypass: begin
                wrAddr = lu_dst;
                wrData = lu_data;
            end
            default: begin
                wrAddr = '0;
                wrData = '0;
            end
        endcase
        rf_we = (grantFifo || grantPipe || bypass) && (wrAddr != '0);
        rf_wa = wrAddr;
        rf_wd = wrData;
    end

    always_comb begin
        countNext = count;
        unique case ({push, pop})
            2'b10:   countNext = count + CntW'(1);
            2'b01:   countNext = count - CntW'(1);
            default: countNext = count;
        endcase
    end

    always_comb begin
        starveNext = starveCnt;
        if (pop || empty) begin
            starveNext = '0;
        end else if (grantPipe) begin
            starveNext = starveCnt + StW'(1);
        end
    end

    // Set after clear so an issue wins over a retiring result.
    always_comb begin
        busyNext = busyQ;
        if (pop) begin
            busyNext[head.dst] = 1'b0;
        end
        if (bypass) begin
            busyNext[lu_dst] = 1'b0;
        end
        if (lu_issue && (lu_issue_dst != '0)) begin
            busyNext[lu_issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= '{dst: lu_dst, data: lu_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            starveCnt <= '0;
            stallQ    <= 1'b0;
            busyQ     <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            count     <= countNext;
            starveCnt <= starveNext;
            stallQ    <= (starveNext == StW'(STARVE_LIMIT));
            busyQ     <= busyNext;
        end
    end

    assign pipe_stall = stallQ;
    assign busy_mask  = busyQ;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter.
// Reference model is queue-based and honours WB_BYPASS_EN like the design.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        bit          stall;
        bit          ready;
        logic [31:0] busy;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_wa = '0;
    logic [63:0] wb_wd = '0;
    logic        pipe_stall;
    logic        lu_issue = 1'b0;
    logic [4:0]  lu_issue_dst = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_dst = '0;
    logic [63:0] lu_data = '0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [63:0] rf_wd;
    logic [31:0] busy_mask;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .pipe_stall(pipe_stall),
        .lu_issue(lu_issue), .lu_issue_dst(lu_issue_dst),
        .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_dst(lu_dst), .lu_data(lu_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wr_t wq[$];
    st_t sq[$];

    wr_t         mq[$];
    int          mStarve = 0;
    bit          mStall = 0;
    logic [31:0] mBusy = '0;
    bit          holdWb = 0;
    bit          hWbv;
    logic [4:0]  hWa;
    logic [63:0] hWd;
    bit          holdLu = 0;
    logic [4:0]  hLd;
    logic [63:0] hLda;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        st_t s;
        wr_t w;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("pipe_stall", 64'(pipe_stall), 64'(s.stall));
            chk("lu_ready", 64'(lu_ready), 64'(s.ready));
            chk("busy_mask", 64'(busy_mask), 64'(s.busy));
            if (rf_we === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write got wa=%0d wd=%h want none",
                             rf_wa, rf_wd);
                end else begin
                    w = wq.pop_front();
                    chk("rf_wa", 64'(rf_wa), 64'(w.a));
                    chk("rf_wd", rf_wd, w.d);
                end
            end
            checks++;
            if (wq.size() != 0) begin
                errors++;
                w = wq.pop_front();
                $display("FAIL missing_write got rf_we=%b want wa=%0d wd=%h",
                         rf_we, w.a, w.d);
                wq.delete();
            end
        end
    end

    task automatic doReset(int n);
        st_t s;
        repeat (n) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            wb_valid = 0; lu_valid = 0; lu_issue = 0;
            mq.delete();
            mStarve = 0; mStall = 0; mBusy = '0;
            holdWb = 0; holdLu = 0;
            s.stall = 0; s.ready = 0; s.busy = '0;
            sq.push_back(s);
        end
    endtask

    task automatic cycle(bit wbv, logic [4:0] wa, logic [63:0] wd,
                         bit luv, logic [4:0] ld, logic [63:0] lda,
                         bit iss, logic [4:0] idst);
        st_t s;
        wr_t e;
        bit ready;
        bit byp;
        int sizeBefore;
        logic [31:0] nb;
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (holdWb) begin
            wbv = hWbv; wa = hWa; wd = hWd;
        end
        if (holdLu) begin
            luv = 1; ld = hLd; lda = hLda;
        end
        wb_valid = wbv; wb_wa = wa; wb_wd = wd;
        lu_valid = luv; lu_dst = ld; lu_data = lda;
        lu_issue = iss; lu_issue_dst = idst;

        sizeBefore = mq.size();
        ready = sizeBefore < DEPTH;
        byp = 0;
`ifdef WB_BYPASS_EN
        byp = (sizeBefore == 0) && !wbv && !mStall && luv;
`endif
        s.stall = mStall; s.ready = ready; s.busy = mBusy;
        sq.push_back(s);

        nb = mBusy;
        if (sizeBefore > 0 && (mStall || !wbv)) begin
            e = mq.pop_front();
            if (e.a != 0) wq.push_back(e);
            nb[e.a] = 1'b0;
            mStarve = 0;
        end else if (wbv && !mStall) begin
            e.a = wa; e.d = wd;
            if (wa != 0) wq.push_back(e);
            if (sizeBefore > 0) mStarve++;
        end
        if (sizeBefore == 0) mStarve = 0;
        if (byp) begin
            e.a = ld; e.d = lda;
            if (ld != 0) wq.push_back(e);
            nb[ld] = 1'b0;
        end
        if (luv && ready && !byp) begin
            e.a = ld; e.d = lda;
            mq.push_back(e);
        end
        if (iss && idst != 0) nb[idst] = 1'b1;

        holdWb = mStall;
        hWbv = wbv; hWa = wa; hWd = wd;
        holdLu = luv && !ready;
        hLd = ld; hLda = lda;
        mStall = (mStarve == LIMIT);
        mBusy = nb;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic runRandom(int n, int wbPct, int luPct, int issPct);
        repeat (n) begin
            cycle($urandom_range(99) < wbPct, 5'($urandom_range(31)),
                  {$urandom, $urandom},
                  $urandom_range(99) < luPct, 5'($urandom_range(7)),
                  {$urandom, $urandom},
                  $urandom_range(99) < issPct, 5'($urandom_range(7)));
        end
    endtask

    initial begin
        doReset(2);
        cycle(1, 5, 64'h1234, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 7);
        cycle(0, 0, 0, 1, 7, 64'hDEAD, 0, 0);
        idle(2);

        cycle(1, 3, 64'h100, 1, 9, 64'hBEEF, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(1, 4, 64'(i + 'h200), 0, 0, 0, 0, 0);
        end
        idle(2);

        for (int i = 0; i < 10; i++) begin
            cycle(1, 6, 64'(i + 'h300), 1, 5'(10 + i), 64'(i + 'h400), 0, 0);
        end
        idle(8);

        cycle(1, 0, 64'hFF, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 64'hAB, 0, 0);
        idle(3);

        cycle(1, 1, 64'h11, 0, 0, 0, 1, 5);
        cycle(1, 2, 64'h22, 1, 9, 64'hA, 1, 6);
        cycle(1, 3, 64'h33, 1, 10, 64'hB, 0, 0);
        doReset(2);
        idle(4);

        runRandom(1200, 50, 40, 30);
        runRandom(800, 95, 60, 30);
        doReset(2);
        runRandom(800, 70, 50, 30);
        idle(DEPTH * (LIMIT + 1) + 4);

        @(negedge clk);
        #1;
        checks++;
        if (wq.size() != 0 || sq.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL drain got wq=%0d sq=%0d mq=%0d want 0",
                     wq.size(), sq.size(), mq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: the in-order pipeline writeback stage (wa/wd) and a multi-cycle long-latency unit (mul/div).
- Buffers long-latency results in a small FIFO and guarantees they eventually drain by stalling the pipeline when starved.
- Keeps a pending-destination scoreboard so decode can interlock on registers still owed by the long-latency unit.
- Sits between writeback and the register file; issue and decode also connect to it.

Parameters:
- DEPTH, 4: long-latency result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may lose arbitration before pipe_stall is forced (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  pipeline writeback has a result this cycle.
- wb_wa  in  5  pipeline destination register (creg_addr_t).
- wb_wd  in  64  pipeline write data (word_t).
- pipe_stall  out  1  pipeline must freeze and hold wb_* stable next cycle.
- lu_issue  in  1  long-latency op issued this cycle.
- lu_issue_dst  in  5  destination of the issued op.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  FIFO accepts result.
- lu_dst  in  5  result destination.
- lu_data  in  64  result data.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  64  register-file write data.
- busy_mask  out  32  bit i = 1 while register i awaits a long-latency result.

Behaviour:
- Reset: asynchronous; FIFO emptied, starve counter = 0, busy_mask = 0. While reset is high, rf_we = 0, pipe_stall = 0, lu_ready = 0. Reset mid-operation discards all buffered results.
- lu_ready = !full, with full computed from occupancy before this cycle's pop. A push happens when lu_valid & lu_ready. Push and pop in the same cycle are allowed; occupancy is unchanged.
- Arbitration is combinational within the cycle. The FIFO head is granted when pipe_stall = 1, or when the FIFO is non-empty and wb_valid = 0. Otherwise the pipeline is granted if wb_valid = 1.
- Grant to pipeline: rf_wa = wb_wa, rf_wd = wb_wd.
- Grant to FIFO: rf_wa/rf_wd come from the head entry, and the head is popped.
- rf_we = grant & (rf_wa != 0). A write to x0 is dropped, but a FIFO entry for x0 is still popped.
- Starve counter:
  - Increments when the FIFO is non-empty and the pipeline wins.
  - Clears on any FIFO pop, or when the FIFO is empty.
- pipe_stall is registered: it is asserted for exactly one cycle in the cycle after the counter reaches STARVE_LIMIT. In that cycle the FIFO wins and the pipeline's wb_* is ignored; the pipeline re-presents the same wb_* the following cycle. The counter clears.
- Scoreboard:
  - lu_issue sets busy_mask[lu_issue_dst] at the clock edge.
  - A FIFO pop clears busy_mask[dst of popped entry].
  - Set and clear of the same bit in the same cycle: the set wins.
  - Bit 0 is never set.
  - Pipeline writes never touch busy_mask. WAW against a busy register is prevented by decode interlock, not here.
- Latency without the optional feature: an accepted result reaches the rf no earlier than 1 cycle after acceptance. The worst case is bounded by (STARVE_LIMIT+1)*DEPTH cycles.

Optional Feature:
- WB_BYPASS_EN defined: when the FIFO is empty, wb_valid = 0, pipe_stall = 0 and lu_valid = 1, the result is written to the rf in the same cycle. The FIFO is not pushed and busy_mask[lu_dst] clears at that edge; lu_ready is 1 in that cycle.
- WB_BYPASS_EN undefined: every result passes through the FIFO (minimum 1 cycle).

Test Plan:
- Reset with FIFO holding 2 entries and busy_mask = 0x0000_0060 -> after reset: rf_we = 0, lu_ready = 1, busy_mask = 0, no stale writes ever appear.
- wb_valid = 1, wb_wa = 5, wb_wd = 0x1234, FIFO empty -> same cycle rf_we = 1, rf_wa = 5, rf_wd = 0x1234; pipe_stall stays 0.
- lu_issue dst = 7, later lu_valid dst = 7 data 0xDEAD with pipeline idle (bypass off) -> next cycle rf write x7 = 0xDEAD; busy_mask[7] goes 1 -> 0 after the pop edge. With WB_BYPASS_EN: write in the acceptance cycle.
- FIFO holds 1 entry, wb_valid held 1 continuously, STARVE_LIMIT = 8 -> pipe_stall pulses once after 8 lost cycles. In that cycle the FIFO entry is written; the next cycle the held pipeline result is written.
- Push 4 results with wb_valid = 1 continuously (DEPTH = 4) -> lu_ready = 0 once full. A 5th lu_valid is held off until a pop, and no data is lost or reordered.
- Pipeline wb_wa = 0 with wb_wd = 0xFF, then FIFO entry with dst 0 -> rf_we = 0 both times; the FIFO entry is still popped.
